// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the two-requester RAM arbiter.
// The read tag records which requester issued a read while it is in flight.
package ram_arbiter_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int ID_W       = 1;

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic vld;
    id_t  id;
  } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from the requests.
// The 1-bit pointer moves past the winner whenever a handshake occurs.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       hs,
  output logic [1:0] gnt
);

  logic ptr;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      if (req[ptr])       gnt[ptr]  = 1'b1;
      else if (req[~ptr]) gnt[~ptr] = 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ptr <= 1'b0;
    else if (hs) ptr <= gnt[0];  // winner 0 -> ptr 1, winner 1 -> ptr 0
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between two requesters. Commands go to the RAM from registers.
// Read data comes back to the issuing requester, steered by a tag delayed to match the RAM.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                ram_wr_en,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_d_in,
  input  logic [DATA_W-1:0]   ram_d_out
);

  logic [1:0]        gnt;
  logic              hs;
  logic              win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  tag_t              new_tag;
  tag_t              tag_q [RD_LAT+1];
  tag_t              tag_exit;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .hs    (hs),
    .gnt   (gnt)
  );

  assign req_ready = gnt;
  assign hs        = |gnt;
  assign win       = gnt[1];
  assign win_we    = win ? req_we[1] : req_we[0];
  assign win_addr  = win ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
  assign win_wdata = win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  assign new_tag   = '{vld: hs & ~win_we, id: win};
  assign tag_exit  = tag_q[RD_LAT];

  // Address and data only move on a handshake; the write strobe is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wr_en <= 1'b0;
      ram_addr  <= '0;
      ram_d_in  <= '0;
    end else begin
      ram_wr_en <= hs & win_we;
      if (hs) begin
        ram_addr <= win_addr;
        ram_d_in <= win_wdata;
      end
    end
  end

  // NOTE: this tag array is reset (unlike a data memory) because a stale valid bit would fire a spurious response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= new_tag;
      for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= {tag_exit.vld & tag_exit.id, tag_exit.vld & ~tag_exit.id};
      if (tag_exit.vld) rsp_rdata <= ram_d_out;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM (RD_LAT=1).
// Expected RAM commands and read responses are queued at each handshake and matched by a monitor.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d_in;
  logic [DW-1:0] ram_d_out;

  always #5 clk = ~clk;

  ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_wr_en (ram_wr_en),
    .ram_addr  (ram_addr),
    .ram_d_in  (ram_d_in),
    .ram_d_out (ram_d_out)
  );

  // Single-port RAM, synchronous read; unwritten locations read as addr ^ 0x3C.
  bit       ram_wr  [256];
  bit [7:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_wr_en) begin
      ram_mem[ram_addr] <= ram_d_in;
      ram_wr[ram_addr]  <= 1'b1;
    end
    ram_d_out <= ram_wr[ram_addr] ? ram_mem[ram_addr] : (ram_addr ^ 8'h3C);
  end

  typedef struct {
    bit       issued;
    logic     we;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_exp_t;

  typedef struct {
    logic       id;
    logic [7:0] data;
    int         cyc;
  } rsp_exp_t;

  cmd_exp_t   cmd_q [$];
  rsp_exp_t   rsp_q [$];
  logic [7:0] shadow [256];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One directed cycle: drive at the falling edge, check the grant, queue what the RAM and requester should see.
  task automatic step(input logic [1:0] v, input logic [1:0] we,
                      input logic [7:0] a0, input logic [7:0] d0,
                      input logic [7:0] a1, input logic [7:0] d1,
                      input logic [1:0] exp_gnt, input string tag);
    cmd_exp_t   ce;
    rsp_exp_t   re;
    logic       g;
    logic [7:0] a;
    logic [7:0] d;
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    #1;
    check({tag, "_gnt"}, 32'(req_ready), 32'(exp_gnt));
    ce = '{issued: 1'b0, we: 1'b0, addr: 8'h00, data: 8'h00};
    if (exp_gnt != 2'b00) begin
      g = exp_gnt[1];
      a = g ? a1 : a0;
      d = g ? d1 : d0;
      ce.issued = 1'b1;
      ce.we     = we[g];
      ce.addr   = a;
      if (we[g]) begin
        ce.data   = d;
        shadow[a] = d;
      end else begin
        re = '{id: g, data: shadow[a], cyc: cyc + 3};
        rsp_q.push_back(re);
      end
    end
    cmd_q.push_back(ce);
  endtask

  always @(negedge clk) begin
    cmd_exp_t ce;
    rsp_exp_t re;
    if (cmd_q.size() > 0) begin
      ce = cmd_q.pop_front();
      if (ce.issued) begin
        check("ram_wr_en", 32'(ram_wr_en), 32'(ce.we));
        check("ram_addr", 32'(ram_addr), 32'(ce.addr));
        if (ce.we) check("ram_d_in", 32'(ram_d_in), 32'(ce.data));
      end else begin
        check("ram_idle_wr_en", 32'(ram_wr_en), 32'(0));
      end
    end
    if (rsp_valid !== 2'b00 || (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc)) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'(0));
      end else begin
        re = rsp_q.pop_front();
        check("rsp_valid", 32'(rsp_valid), re.id ? 32'h2 : 32'h1);
        check("rsp_rdata", 32'(rsp_rdata), 32'(re.data));
        check("rsp_cycle", 32'(cyc), 32'(re.cyc));
      end
    end
  end

  initial begin
    int i0;
    int i1;
    logic [1:0] eg;
    for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'h3C;

    // Reset values with no clock edge yet.
    #1;
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
    check("rst_ram_wr_en", 32'(ram_wr_en), 32'(0));
    check("rst_ram_addr", 32'(ram_addr), 32'(0));
    check("rst_ram_d_in", 32'(ram_d_in), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // 1: read in flight, then reset for one cycle; the read must vanish and the pointer return to 0.
    step(2'b01, 2'b00, 8'h03, 8'h00, 8'h00, 8'h00, 2'b01, "t1_rd");
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b11;
    cmd_q.delete();
    rsp_q.delete();
    #1;
    check("t1_rst_ready", 32'(req_ready), 32'(0));
    check("t1_rst_wr_en", 32'(ram_wr_en), 32'(0));
    check("t1_rst_rsp", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    #2;
    check("t1_rst_ready2", 32'(req_ready), 32'(0));
    check("t1_rst_wr_en2", 32'(ram_wr_en), 32'(0));
    req_valid = 2'b00;
    req_we    = 2'b00;
    rst_n     = 1'b1;

    // 3: contention from reset; first grant to requester 0 shows the pointer was cleared.
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 6; k++) begin
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      step(2'b11, 2'b11, 8'(8'h10 + i0), 8'(8'hC0 + i0), 8'(8'h20 + i1), 8'(8'hD0 + i1), eg, "t3");
      if (eg == 2'b01) i0++;
      else i1++;
    end

    // 2: write then read back from requester 0 alone.
    step(2'b01, 2'b01, 8'h05, 8'hA5, 8'h00, 8'h00, 2'b01, "t2_wr");
    step(2'b01, 2'b00, 8'h05, 8'h00, 8'h00, 8'h00, 2'b01, "t2_rd");

    // 4: point at requester 0, then same-address write (req0) and read (req1) together.
    step(2'b10, 2'b00, 8'h00, 8'h00, 8'h40, 8'h00, 2'b10, "t4_pre");
    step(2'b11, 2'b01, 8'h20, 8'h77, 8'h20, 8'h00, 2'b01, "t4_wr");
    step(2'b10, 2'b00, 8'h00, 8'h00, 8'h20, 8'h00, 2'b10, "t4_rd");

    // 5: back-to-back reads of 0x00..0x07.
    for (int i = 0; i < 8; i++)
      step(2'b01, 2'b00, 8'(i), 8'h00, 8'h00, 8'h00, 2'b01, "t5");

    // 6: requester 1 waits behind a streaming requester 0, then its write is read back.
    step(2'b10, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, "t6_pre");
    step(2'b11, 2'b10, 8'h08, 8'h00, 8'h55, 8'h99, 2'b01, "t6_c0");
    step(2'b11, 2'b10, 8'h09, 8'h00, 8'h55, 8'h99, 2'b10, "t6_c1");
    step(2'b01, 2'b00, 8'h55, 8'h00, 8'h00, 8'h00, 2'b01, "t6_rd");

    repeat (4) step(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, "idle");
    @(negedge clk);
    #2;
    check("rsp_q_drained", 32'(rsp_q.size()), 32'(0));
    check("cmd_q_drained", 32'(cmd_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
